// File: rtl/mac_acc_block_if.sv
// Beat-in / result-out bundle for mac_acc_block: mode, enable, four products, both handshakes
// and the per-group status flags.
interface mac_acc_block_if #(
  parameter int unsigned MIN_W  = 8,
  parameter int unsigned IN_W   = 5 * MIN_W,
  parameter int unsigned ACC_W  = 8 * MIN_W,
  parameter int unsigned CONF_W = 2
);
  logic              en;
  logic [CONF_W-1:0] cfg;
  logic [IN_W-1:0]   P0;
  logic [IN_W-1:0]   P1;
  logic [IN_W-1:0]   P2;
  logic [IN_W-1:0]   P3;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        ovf;
  logic              cfg_err;

  modport master (
    output en, cfg, P0, P1, P2, P3, in_valid, in_last, out_ready,
    input  in_ready, acc_out, out_valid, ovf, cfg_err
  );

  modport slave (
    input  en, cfg, P0, P1, P2, P3, in_valid, in_last, out_ready,
    output in_ready, acc_out, out_valid, ovf, cfg_err
  );
endinterface

// File: rtl/mac_acc_block.sv
// SIMD accumulator behind the four multiply blocks: SINGLE/DUAL/QUAD lane products, unsigned.
// Optional MAC_ACC_SAT_EN: lanes saturate to all-ones on carry-out instead of wrapping.
module mac_acc_block #(
  parameter int unsigned MIN_W = 8,
  parameter int unsigned IN_W  = 5 * MIN_W,
  parameter int unsigned ACC_W = 8 * MIN_W
) (
  input logic           clk,
  input logic           rst,
  mac_acc_block_if.slave bus
);

  localparam int unsigned L1W = 2 * MIN_W;
  localparam int unsigned L2W = 4 * MIN_W;

  localparam logic [1:0] MacSingle = 2'd0;
  localparam logic [1:0] MacDual   = 2'd1;
  localparam logic [1:0] MacQuad   = 2'd2;

  typedef enum logic {StAcc, StDrain} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_out_q;
  logic [3:0]       ovf_q;
  logic             cfg_err_q;
  logic             first_q;
  logic [1:0]       mode_q;

  logic [IN_W-1:0]  p [4];
  logic [ACC_W-1:0] base, sum_single, sum_dual, sum_quad, acc_upd, lq;
  logic [L2W-1:0]   ld [2];
  logic [3:0]       cy_single, cy;
  logic [1:0]       cy_dual;
  logic             cy_quad;
  logic [1:0]       mode;
  logic             bad_mode;
  logic             beat, out_hs;

  assign p[0] = bus.P0;
  assign p[1] = bus.P1;
  assign p[2] = bus.P2;
  assign p[3] = bus.P3;

  assign beat   = (state_q == StAcc) && bus.en && bus.in_valid;
  assign out_hs = (state_q == StDrain) && bus.out_ready;

  // The first beat of a group uses the live cfg; later beats use the latched mode.
  assign mode = first_q ? bus.cfg[1:0] : mode_q;

  always_comb begin
    base       = first_q ? '0 : acc_q;
    sum_single = '0;
    sum_dual   = '0;
    cy_single  = '0;
    cy_dual    = '0;
    for (int n = 0; n < 4; n++) begin
      {cy_single[n], sum_single[n*L1W +: L1W]} =
          {1'b0, base[n*L1W +: L1W]} + {1'b0, p[n][L1W-1:0]};
`ifdef MAC_ACC_SAT_EN
      if (cy_single[n]) sum_single[n*L1W +: L1W] = '1;
`endif
    end
    for (int k = 0; k < 2; k++) begin
      ld[k] = L2W'(ACC_W'(p[2*k]) + (ACC_W'(p[2*k+1]) << MIN_W));
      {cy_dual[k], sum_dual[k*L2W +: L2W]} = {1'b0, base[k*L2W +: L2W]} + {1'b0, ld[k]};
`ifdef MAC_ACC_SAT_EN
      if (cy_dual[k]) sum_dual[k*L2W +: L2W] = '1;
`endif
    end
    lq = ACC_W'(p[0]) + (ACC_W'(p[1]) << MIN_W) + (ACC_W'(p[2]) << (2 * MIN_W)) +
         (ACC_W'(p[3]) << (3 * MIN_W));
    {cy_quad, sum_quad} = {1'b0, base} + {1'b0, lq};
`ifdef MAC_ACC_SAT_EN
    if (cy_quad) sum_quad = '1;
`endif
  end

  always_comb begin
    acc_upd  = base;
    cy       = '0;
    bad_mode = 1'b0;
    case (mode)
      MacSingle: begin
        acc_upd = sum_single;
        cy      = cy_single;
      end
      MacDual: begin
        acc_upd = sum_dual;
        cy      = {2'b00, cy_dual};
      end
      MacQuad: begin
        acc_upd = sum_quad;
        cy      = {3'b000, cy_quad};
      end
      // Undefined mode contributes zero products and flags the group.
      default: bad_mode = 1'b1;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state_q)
      StAcc: begin
        bus.in_ready = bus.en;
        if (beat && bus.in_last) state_d = StDrain;
      end
      StDrain: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = StAcc;
      end
      default: state_d = StAcc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StAcc;
      acc_q     <= '0;
      acc_out_q <= '0;
      ovf_q     <= '0;
      cfg_err_q <= 1'b0;
      first_q   <= 1'b1;
      mode_q    <= MacSingle;
    end else begin
      state_q <= state_d;
      if (beat) begin
        acc_q   <= acc_upd;
        ovf_q   <= (first_q ? 4'b0000 : ovf_q) | cy;
        first_q <= 1'b0;
        if (first_q) begin
          mode_q    <= bus.cfg[1:0];
          cfg_err_q <= bad_mode;
        end
        if (bus.in_last) acc_out_q <= acc_upd;
      end
      if (out_hs) first_q <= 1'b1;
    end
  end

  assign bus.acc_out = acc_out_q;
  assign bus.ovf     = ovf_q;
  assign bus.cfg_err = cfg_err_q;

endmodule

// File: tb/tb_mac_acc_block.sv
// Self-checking bench for mac_acc_block: vector table driven through a scoreboard plus
// hand sequences for backpressure, enable gating and mid-group reset.
module tb_mac_acc_block;

  localparam logic [1:0] Sgl = 2'd0;
  localparam logic [1:0] Dul = 2'd1;
  localparam logic [1:0] Qd  = 2'd2;
  localparam logic [1:0] Bad = 2'd3;

`ifdef MAC_ACC_SAT_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_acc_block_if bus ();

  mac_acc_block dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [63:0] acc;
    logic [3:0]  ovf;
    logic        err;
  } res_t;

  typedef struct {
    string       name;
    logic [1:0]  cfg;
    logic [1:0]  cfg2;
    int          beats;
    logic [39:0] p0, p1, p2, p3;
    logic [63:0] acc;
    logic [3:0]  ovf;
    logic        err;
  } vec_t;

  res_t sb[$];
  vec_t vecs[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic [1:0] c, input logic [1:0] c2,
                              input int bt, input logic [39:0] a, input logic [39:0] b,
                              input logic [39:0] d, input logic [39:0] e,
                              input logic [63:0] acc, input logic [3:0] o, input logic er);
    vec_t v;
    v.name = nm; v.cfg = c; v.cfg2 = c2; v.beats = bt;
    v.p0 = a; v.p1 = b; v.p2 = d; v.p3 = e;
    v.acc = acc; v.ovf = o; v.err = er;
    return v;
  endfunction

  // Results are compared when the DUT completes its output handshake.
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_result: got %h, expected none", bus.acc_out);
      end else begin
        res_t r;
        r = sb.pop_front();
        check("acc_out", bus.acc_out, r.acc);
        check("ovf", 64'(bus.ovf), 64'(r.ovf));
        check("cfg_err", 64'(bus.cfg_err), 64'(r.err));
      end
    end
  end

  task automatic send_beat(input logic [1:0] c, input logic [39:0] a, input logic [39:0] b,
                           input logic [39:0] d, input logic [39:0] e, input logic last);
    int n;
    @(negedge clk);
    bus.cfg = c;
    bus.P0 = a; bus.P1 = b; bus.P2 = d; bus.P3 = e;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      fails++;
      $display("FAIL beat_timeout: got in_ready=0, expected 1");
    end
    @(posedge clk);
  endtask

  task automatic send_group(input vec_t v);
    for (int b = 0; b < v.beats; b++) begin
      send_beat((b == 0) ? v.cfg : v.cfg2, v.p0, v.p1, v.p2, v.p3, b == v.beats - 1);
    end
    sb.push_back('{acc: v.acc, ovf: v.ovf, err: v.err});
    @(negedge clk);
    check({v.name, "_latency"}, 64'(bus.out_valid), 64'd1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(bus.in_ready && !bus.out_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("idle", 64'(bus.in_ready && !bus.out_valid), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.en = 1'b1; bus.cfg = Sgl;
    bus.P0 = '0; bus.P1 = '0; bus.P2 = '0; bus.P3 = '0;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b1;

    vecs.push_back(mk("single3", Sgl, Sgl, 3, 10, 20, 30, 40, 64'h0078_005A_003C_001E, 0, 0));
    vecs.push_back(mk("dual1", Dul, Dul, 1, 40'h100, 2, 0, 1, 64'h0000_0100_0000_0300, 0, 0));
    vecs.push_back(mk("quad2", Qd, Qd, 2, 1, 1, 1, 1, 64'h0000_0000_0202_0202, 0, 0));
    vecs.push_back(mk("quad_flip", Qd, Sgl, 2, 1, 1, 1, 1, 64'h0000_0000_0202_0202, 0, 0));
    vecs.push_back(mk("single_ovf", Sgl, Sgl, 2, 40'hFF00, 0, 0, 0,
                      Sat ? 64'h0000_0000_0000_FFFF : 64'h0000_0000_0000_FE00, 4'b0001, 0));
    vecs.push_back(mk("single_ovf2", Sgl, Sgl, 2, 40'h8000, 40'h8001, 40'h7FFF, 40'h1_0000,
                      Sat ? 64'h0000_FFFE_FFFF_FFFF : 64'h0000_FFFE_0002_0000, 4'b0011, 0));
    vecs.push_back(mk("dual_ovf", Dul, Dul, 2, 40'h8000_0000, 0, 0, 0,
                      Sat ? 64'h0000_0000_FFFF_FFFF : 64'h0, 4'b0001, 0));
    vecs.push_back(mk("quad_ovf", Qd, Qd, 2, 0, 0, 0, 40'hFF_0000_0000,
                      Sat ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFE00_0000_0000_0000, 4'b0001, 0));

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_acc_out", bus.acc_out, 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_ovf", 64'(bus.ovf), 64'd0);
    check("rst_cfg_err", 64'(bus.cfg_err), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    foreach (vecs[i]) begin
      send_group(vecs[i]);
      wait_idle();
    end

    // Backpressure: result must hold while out_ready is low.
    bus.out_ready = 1'b0;
    send_group(mk("bp", Sgl, Sgl, 1, 1, 2, 3, 4, 64'h0004_0003_0002_0001, 0, 0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_acc_stable", bus.acc_out, 64'h0004_0003_0002_0001);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    check("hs_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    check("post_hs_out_valid", 64'(bus.out_valid), 64'd0);
    check("post_hs_in_ready", 64'(bus.in_ready), 64'd1);

    // Enable low: offered beats must not be taken.
    bus.en = 1'b0;
    bus.cfg = Sgl;
    bus.P0 = 9; bus.P1 = 9; bus.P2 = 9; bus.P3 = 9;
    bus.in_valid = 1'b1; bus.in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("en0_in_ready", 64'(bus.in_ready), 64'd0);
      check("en0_out_valid", 64'(bus.out_valid), 64'd0);
    end
    bus.en = 1'b1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    send_group(mk("fresh", Sgl, Sgl, 1, 1, 1, 1, 1, 64'h0001_0001_0001_0001, 0, 0));
    wait_idle();

    // Reset after two of four beats, with a lane overflow already recorded.
    send_beat(Sgl, 40'hFFFF, 1, 1, 1, 1'b0);
    send_beat(Sgl, 40'hFFFF, 1, 1, 1, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_acc_out", bus.acc_out, 64'd0);
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_ovf", 64'(bus.ovf), 64'd0);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);

    send_group(mk("quad5", Qd, Qd, 1, 5, 0, 0, 0, 64'd5, 0, 0));
    wait_idle();
    send_group(mk("bad_cfg", Bad, Bad, 1, 7, 7, 7, 7, 64'd0, 0, 1));
    wait_idle();
    send_group(mk("err_clear", Sgl, Sgl, 1, 2, 2, 2, 2, 64'h0002_0002_0002_0002, 0, 0));
    wait_idle();

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mac_acc_block.md
Name: mac_acc_block

Overview:
- Accumulator stage directly downstream of the four `mac_mul_block_n` instances.
- Takes the four per-block product outputs, combines them into SIMD lane products according to `cfg` (SINGLE / DUAL / QUAD), and adds them into a `4*MIN_W*2`-bit accumulator.
- Accepts a group of beats through a valid/ready handshake and presents the final accumulated result downstream through a second valid/ready handshake.
- Unsigned arithmetic throughout, matching the unsigned multiply units.

Parameters:
- `MIN_W`, default `MAC_MIN_WIDTH` (8): base operand width; lane and shift granularity.
- `IN_W`, default `5*MIN_W` (40): width of each product input `P0`..`P3`.
- `ACC_W`, default `8*MIN_W` (64): accumulator width. Fixed at `8*MIN_W`; other values are unsupported.

Ports:
- `clk` input 1: clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: block enable; gates acceptance of input beats only.
- `cfg` input `MAC_CONF_WIDTH`: mode, decoded from `cfg[1:0]` as `MAC_SINGLE` / `MAC_DUAL` / `MAC_QUAD`.
- `P0`..`P3` input `IN_W` each: product outputs of mul blocks 0..3.
- `in_valid` input 1: beat present on `P0`..`P3`.
- `in_last` input 1: final beat of the accumulation group.
- `in_ready` output 1: beat accepted when `in_valid && in_ready`.
- `acc_out` output `ACC_W`: accumulated result, lanes packed with lane 0 in the LSBs.
- `out_valid` output 1: `acc_out` is valid.
- `out_ready` input 1: downstream accepts the result.
- `ovf` output 4: sticky per-lane carry-out flags for the current group.
- `cfg_err` output 1: the group was started with an undefined `cfg` value.

Behaviour:
- Reset: `acc_out = 0`, accumulator = 0, `out_valid = 0`, `ovf = 0`, `cfg_err = 0`, state = ACC, `first = 1`.
- FSM states:
  - ACC: `in_ready = en`.
  - DRAIN: `in_ready = 0`, `out_valid = 1`.
- Lane product formation, computed combinationally from `P0`..`P3` at the accepted beat:
  - SINGLE: four 16-bit lanes. `Ln = Pn[2*MIN_W-1:0]`, for n = 0..3.
  - DUAL: two 32-bit lanes. `L0 = P0 + (P1 << MIN_W)`, `L1 = P2 + (P3 << MIN_W)`, each truncated to 32 bits.
  - QUAD: one 64-bit lane. `L0 = P0 + (P1 << MIN_W) + (P2 << 2*MIN_W) + (P3 << 3*MIN_W)`, truncated to 64 bits.
  - Undefined cfg: all lane products are 0, and `cfg_err` is set for the group.
- Mode latching:
  - The mode is latched on the first accepted beat of a group, i.e. while `first = 1`.
  - Changes to `cfg` mid-group are ignored until the next group.
- Accepted beat:
  - Each lane becomes `(first ? 0 : lane) + Ln`, computed modulo the lane width.
  - If the lane carries out, the corresponding `ovf` bit is set:
    - SINGLE: bits 3..0.
    - DUAL: bits 1..0.
    - QUAD: bit 0.
    - Unused `ovf` bits stay 0.
  - `first` is cleared.
  - If `first = 1`, `ovf` and `cfg_err` are first cleared, then updated by this beat.
- Accepted beat with `in_last = 1`:
  - On the same edge, `acc_out` is loaded with the updated accumulator and the state moves to DRAIN.
  - `out_valid` is high on the following cycle. Latency is one cycle from acceptance of the last beat.
  - A single-beat group (`first` and `last` on the same beat) is legal.
- DRAIN:
  - `acc_out`, `ovf` and `cfg_err` are held stable until `out_ready`.
  - On `out_valid && out_ready`: `out_valid` goes to 0, `first` is set to 1, and the state returns to ACC.
  - `in_ready` stays 0 during the handshake cycle and rises on the next cycle, so there is no same-cycle turnaround.
- `en = 0`:
  - No beats are accepted and the accumulator holds its value.
  - The DRAIN handshake still completes.
- `in_valid = 0`: the accumulator holds its value, and `in_last` is ignored.
- `rst` asserted mid-group or in DRAIN: everything returns to reset values at the next edge, and any pending result is discarded.
- `ovf` and `cfg_err` remain valid until the first beat of the next group.

Optional Feature:
- Macro: `MAC_ACC_SAT_EN`.
- Defined: on a lane carry-out, the lane saturates to all-ones of its width instead of wrapping. It then stays saturated for the rest of the group. `ovf` is still set.
- Undefined: lanes wrap modulo the lane width, and only `ovf` flags the overflow.

Test Plan:
- SINGLE, 3 beats each `P0..P3 = 10, 20, 30, 40`, `in_last` on beat 3 → one cycle later `out_valid = 1`, `acc_out = 0x0078_005A_003C_001E`, `ovf = 0`.
- DUAL, 1 beat `P0 = 0x100`, `P1 = 0x2`, `P2 = 0`, `P3 = 0x1`, `in_last = 1` → `acc_out = 0x00000100_00000300`.
- QUAD, 2 beats each `P0..P3 = 1`, `in_last` on beat 2 → `acc_out = 0x0000_0000_0202_0202`. Flip `cfg` to SINGLE between the beats → result unchanged.
- SINGLE, 2 beats `P0 = 0xFF00`, others 0:
  - Without `MAC_ACC_SAT_EN` → lane 0 = `0xFE00`, `ovf = 4'b0001`.
  - With `MAC_ACC_SAT_EN` → lane 0 = `0xFFFF`, `ovf = 4'b0001`.
- Backpressure: hold `out_ready = 0` for 5 cycles after a result → `out_valid` stays 1, `acc_out` stays stable, `in_ready = 0`. Then `out_ready = 1` → `out_valid = 0` next cycle and `in_ready = 1` the cycle after. The next group starts from 0.
- Assert `rst` after 2 of 4 beats → outputs reset to 0. A new group of 1 QUAD beat `P0 = 5`, `in_last = 1` → `acc_out = 5`. Also drive `cfg` undefined on a group → `acc_out = 0`, `cfg_err = 1`.
